mem_arbiter: RTL

Single-port access arbiter and load formatter placed directly upstream of the unified byte-addressed instruction/data memory. It accepts instruction-fetch requests and load/store requests from the core and serialises them onto the one memory port. It extracts and extends sub-word load data, rejects misaligned data accesses, and returns registered responses with a one-cycle acknowledge pulse.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port arbiter between instruction fetch and load/store traffic in front of
// the unified byte-addressed memory; formats sub-word loads and rejects misaligned accesses.
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_wena,
  output logic              mem_ba,
  output logic              mem_ha,
  output logic              mem_ua,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;
  typedef enum logic {GNT_DATA, GNT_FETCH} grant_t;

  state_t              state_q, state_d;
  grant_t              grant_q, last_grant_q;
  logic [ADDR_W-1:0]   a_addr;
  logic [1:0]          a_size;
  logic                a_we;
  logic                a_uns;
  logic [31:0]         a_wdata;
  logic                grant_data;
  logic                d_bad;
  logic [31:0]         load_ext;
  logic                unused_addr_bits;

  // Addresses alias by truncation; the high bits are deliberately ignored.
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // Data wins when alone or when fetch was the last port served.
  assign grant_data = d_req && (!if_req || (last_grant_q == GNT_FETCH));
  assign d_bad      = (d_size == 2'b11)
                   || ((d_size == 2'b01) && d_addr[0])
                   || ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data)  state_d = d_bad ? DONE : D_ACC;
        else if (if_req) state_d = I_ACC;
      end
      D_ACC:   state_d = DONE;
      I_ACC:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ext = mem_dout;
    case (a_size)
      2'b00:   load_ext = a_uns ? {24'h0, mem_dout[7:0]}  : {{24{mem_dout[7]}}, mem_dout[7:0]};
      2'b01:   load_ext = a_uns ? {16'h0, mem_dout[15:0]} : {{16{mem_dout[15]}}, mem_dout[15:0]};
      default: load_ext = mem_dout;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_FETCH;
      last_grant_q <= GNT_FETCH;
      a_addr       <= '0;
      a_size       <= 2'b00;
      a_we         <= 1'b0;
      a_uns        <= 1'b0;
      a_wdata      <= 32'h0;
      if_rdata     <= 32'h0;
      d_rdata      <= 32'h0;
      d_err        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            grant_q <= GNT_DATA;
            a_addr  <= d_addr[ADDR_W-1:0];
            a_size  <= d_size;
            a_we    <= d_we;
            a_uns   <= d_unsigned;
            a_wdata <= d_wdata;
            // Rejected accesses answer immediately; memory is never touched.
            if (d_bad) begin
              d_err   <= 1'b1;
              d_rdata <= 32'h0;
            end
          end else if (if_req) begin
            grant_q <= GNT_FETCH;
            a_addr  <= if_addr[ADDR_W-1:0];
            a_size  <= 2'b10;
            a_we    <= 1'b0;
            a_uns   <= 1'b0;
          end
        end
        D_ACC: begin
          d_err   <= 1'b0;
          d_rdata <= a_we ? 32'h0 : load_ext;
        end
        I_ACC:   if_rdata     <= mem_dout;
        DONE:    last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

  // Memory strobes come only from registered state, never from the request inputs.
  assign mem_wena = (state_q == D_ACC) && a_we;
  assign mem_ba   = (state_q == D_ACC) && (a_size == 2'b00);
  assign mem_ha   = (state_q == D_ACC) && (a_size == 2'b01);
  assign mem_ua   = (state_q == D_ACC) && a_uns;
  assign mem_din  = (state_q == D_ACC) ? a_wdata : 32'h0;
  assign mem_addr = ((state_q == D_ACC) || (state_q == I_ACC)) ? a_addr : '0;

  assign if_ack = (state_q == DONE) && (grant_q == GNT_FETCH);
  assign d_ack  = (state_q == DONE) && (grant_q == GNT_DATA);

endmodule
